// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   state_e    : scan FSM states (IDLE / BLANK / SHOW)
//   SEG7_TABLE : hex digit -> segment pattern, bit order gfedcba, active-high
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame-write handshake bus of the scan controller.
//   wr_valid : new frame offered (master -> slave)
//   wr_ready : shadow buffer free (slave -> master)
//   wr_data  : NUM_DIGITS hex digits, digit i at [4i+3:4i]
//   wr_dp    : one decimal point per digit
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [4*NUM_DIGITS-1:0] wr_data;
    logic [NUM_DIGITS-1:0]   wr_dp;

    modport master (output wr_valid, output wr_data, output wr_dp, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, input  wr_dp, output wr_ready);
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to seven-segment decoder.
//   hex : 4-bit digit value
//   seg : segment pattern gfedcba, active-high
module hex_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = SEG7_TABLE[hex];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered frame.
//   clk, rst     : clock, synchronous active-high reset
//   enable       : 1 = scan, 0 = display off
//   wr           : frame-write handshake (slave side)
//   leds         : {dp, gfedcba} of the digit being shown, 0 while blank/idle
//   digit_sel    : one-hot active digit, 0 while blank/idle
//   frame_done   : pulse on the last SHOW cycle of the last digit
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    seg_scan_ctrl_if.slave        wr,
    output logic [7:0]            leds,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_done
);
    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    // Each digit starts with a blank phase unless blanking is disabled.
    localparam state_e           FIRST_STATE = (BLANK_CYCLES > 0) ? BLANK : SHOW;
    localparam logic [CNT_W-1:0] FIRST_LOAD  = (BLANK_CYCLES > 0) ? BLANK_LOAD : DWELL_LOAD;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d, active_q, active_d;
    logic [NUM_DIGITS-1:0]      shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
    logic                       pending_q, pending_d;
    logic                       wr_ready_q, wr_ready_d;
    logic [7:0]                 leds_q, leds_d;
    logic [NUM_DIGITS-1:0]      digit_sel_q, digit_sel_d;
    logic                       frame_done_q, frame_done_d;
    logic                       promote;
    logic [6:0]                 seg;

    // Decoded from the next-cycle buffer/index so the registered leds line up with state.
    hex_to_seg7 u_hex_to_seg7 (
        .hex (active_d[idx_d]),
        .seg (seg)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        active_d     = active_q;
        active_dp_d  = active_dp_q;
        pending_d    = pending_q;
        leds_d       = 8'h00;
        digit_sel_d  = '0;
        frame_done_d = 1'b0;

        // Promotion and acceptance never overlap: wr_ready is low while pending.
        promote = pending_q && (state_q == IDLE || frame_done_q);
        if (promote) begin
            active_d    = shadow_q;
            active_dp_d = shadow_dp_q;
            pending_d   = 1'b0;
        end else if (wr.wr_valid && wr_ready_q) begin
            shadow_d    = wr.wr_data;
            shadow_dp_d = wr.wr_dp;
            pending_d   = 1'b1;
        end

        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FIRST_STATE;
                    idx_d   = '0;
                    cnt_d   = FIRST_LOAD;
                end
                BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = SHOW;
                        cnt_d   = DWELL_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == '0) begin
                        state_d = FIRST_STATE;
                        cnt_d   = FIRST_LOAD;
                        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        if (state_d == SHOW) begin
            leds_d       = {active_dp_d[idx_d], seg};
            digit_sel_d  = NUM_DIGITS'(1) << idx_d;
            frame_done_d = (idx_d == LAST_IDX) && (cnt_d == '0);
        end

        wr_ready_d = ~pending_d;
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    // NOTE: the frame buffers are cleared by reset because a reset display must show all zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            wr_ready_q   <= 1'b0;
            leds_q       <= 8'h00;
            digit_sel_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            active_q     <= active_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            wr_ready_q   <= wr_ready_d;
            leds_q       <= leds_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr.wr_ready = wr_ready_q;
    assign leds        = leds_q;
    assign digit_sel   = digit_sel_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, dwell 4, blank 1, 20-cycle frame).
module tb_seg_scan_ctrl;

    localparam int ND = 4;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] leds;
        logic       fd;
    } exp_t;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [7:0]    leds;
    logic [ND-1:0] digit_sel;
    logic          frame_done;

    exp_t sb_q[$];
    bit   mon_en = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) wr_if ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr         (wr_if),
        .leds       (leds),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Advance one cycle; when scanning is monitored, pop and compare one expected cycle.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: got sel=%b leds=%h fd=%b, no entry expected", digit_sel, leds, frame_done);
            end else begin
                e = sb_q.pop_front();
                if ({digit_sel, leds, frame_done} !== e) begin
                    n_err++;
                    $display("FAIL sb_cycle @%0t: got sel=%b leds=%h fd=%b, expected sel=%b leds=%h fd=%b",
                             $time, digit_sel, leds, frame_done, e.sel, e.leds, e.fd);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Expected per-cycle outputs for the first ncyc cycles of a frame.
    task automatic push_frame(input logic [15:0] data, input logic [3:0] dp, input int ncyc);
        int   c;
        exp_t e;
        logic [3:0] nib;
        c = 0;
        for (int d = 0; d < ND; d++) begin
            if (c < ncyc) sb_q.push_back('0);
            c++;
            nib = data[4*d +: 4];
            for (int k = 0; k < 4; k++) begin
                e.sel  = 4'(1 << d);
                e.leds = {dp[d], SEG_TAB[nib]};
                e.fd   = (d == ND - 1) && (k == 3);
                if (c < ncyc) sb_q.push_back(e);
                c++;
            end
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sb_q.push_back('0);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            step();
            guard++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d entries left, required 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({wr_if.wr_ready, leds, digit_sel, frame_done} !== 14'h0) begin
                n_err++;
                $display("FAIL reset_outputs: got rdy=%b leds=%h sel=%b fd=%b, required all 0",
                         wr_if.wr_ready, leds, digit_sel, frame_done);
            end
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (wr_if.wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got %b, required 1", wr_if.wr_ready);
        end
        for (int i = 0; i < 50; i++) begin
            step();
            n_cmp++;
            if ({leds, digit_sel, frame_done} !== 13'h0) begin
                n_err++;
                $display("FAIL idle_off: got leds=%h sel=%b fd=%b, required all 0", leds, digit_sel, frame_done);
            end
        end
    endtask

    task automatic test_idle_write_scan();
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 16'h1234;
        wr_if.wr_dp    = 4'b0001;
        step();
        wr_if.wr_valid = 1'b0;
        n_cmp++;
        if (wr_if.wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_fall: got %b, required 0", wr_if.wr_ready);
        end
        step();
        n_cmp++;
        if (wr_if.wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_idle_promote: got %b, required 1", wr_if.wr_ready);
        end
        enable = 1'b1;
        mon_en = 1'b1;
        push_frame(16'h1234, 4'b0001, 20);
        push_frame(16'h1234, 4'b0001, 20);
        wait_drain();
    endtask

    task automatic test_midframe_write();
        push_frame(16'h1234, 4'b0001, 20);
        push_frame(16'h8888, 4'b0000, 20);
        steps(7);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 16'h8888;
        wr_if.wr_dp    = 4'b0000;
        step();
        wr_if.wr_valid = 1'b0;
        n_cmp++;
        if (wr_if.wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_ready_fall: got %b, required 0", wr_if.wr_ready);
        end
        steps(12);
        n_cmp++;
        if ({wr_if.wr_ready, frame_done} !== 2'b01) begin
            n_err++;
            $display("FAIL frame_end_state: got rdy=%b fd=%b, required rdy=0 fd=1", wr_if.wr_ready, frame_done);
        end
        step();
        n_cmp++;
        if (wr_if.wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_promote: got %b, required 1", wr_if.wr_ready);
        end
    endtask

    task automatic test_back_to_back();
        int waits;
        step();
        push_frame(16'h5678, 4'b0000, 20);
        push_frame(16'h9ABC, 4'b1111, 20);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 16'h5678;
        wr_if.wr_dp    = 4'b0000;
        step();
        wr_if.wr_data  = 16'h9ABC;
        wr_if.wr_dp    = 4'b1111;
        waits = 0;
        while (wr_if.wr_ready !== 1'b1 && waits < 50) begin
            step();
            waits++;
        end
        n_cmp++;
        if (waits != 18) begin
            n_err++;
            $display("FAIL held_write_wait: got %0d cycles, required 18", waits);
        end
        step();
        wr_if.wr_valid = 1'b0;
        n_cmp++;
        if (wr_if.wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL held_write_accept: got rdy=%b, required 0", wr_if.wr_ready);
        end
        wait_drain();
        n_cmp++;
        if (wr_if.wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_b2b: got %b, required 1", wr_if.wr_ready);
        end
    endtask

    task automatic test_disable();
        push_frame(16'h9ABC, 4'b1111, 13);
        push_idle(3);
        steps(13);
        enable = 1'b0;
        step();
        n_cmp++;
        if ({leds, digit_sel, frame_done} !== 13'h0) begin
            n_err++;
            $display("FAIL disable_off: got leds=%h sel=%b fd=%b, required all 0", leds, digit_sel, frame_done);
        end
        steps(2);
        enable = 1'b1;
        push_frame(16'h9ABC, 4'b1111, 20);
    endtask

    task automatic test_reset_midframe();
        step();
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 16'hFFFF;
        wr_if.wr_dp    = 4'b1111;
        step();
        wr_if.wr_valid = 1'b0;
        n_cmp++;
        if (wr_if.wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL pending_before_reset: got rdy=%b, required 0", wr_if.wr_ready);
        end
        steps(2);
        mon_en = 1'b0;
        sb_q.delete();
        rst    = 1'b1;
        enable = 1'b0;
        step();
        n_cmp++;
        if ({wr_if.wr_ready, leds, digit_sel, frame_done} !== 14'h0) begin
            n_err++;
            $display("FAIL midframe_reset: got rdy=%b leds=%h sel=%b fd=%b, required all 0",
                     wr_if.wr_ready, leds, digit_sel, frame_done);
        end
        step();
        rst = 1'b0;
        step();
        n_cmp++;
        if (wr_if.wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_midreset: got %b, required 1", wr_if.wr_ready);
        end
        enable = 1'b1;
        mon_en = 1'b1;
        push_frame(16'h0000, 4'b0000, 20);
        push_frame(16'h0000, 4'b0000, 20);
        wait_drain();
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        wr_if.wr_dp    = '0;
        test_reset();
        test_idle_write_scan();
        test_midframe_write();
        test_back_to_back();
        test_disable();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
